// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point vector accumulator sequencer.
package fp_pkg;

    localparam logic [31:0] FP_POS_ZERO = 32'h00000000;
    localparam logic [31:0] FP_QNAN     = 32'hFFC00000;

    typedef enum logic [2:0] {
        WAIT_IN  = 3'd0,
        ISSUE    = 3'd1,
        WAIT_ADD = 3'd2,
        DRAIN    = 3'd3,
        DONE     = 3'd4
    } state_t;

    // A vector that saw an adder timeout reports a quiet NaN instead of its partial sum.
    function automatic logic [31:0] sel_result(input logic err, input logic [31:0] sum);
        if (err) begin
            sel_result = FP_QNAN;
        end else begin
            sel_result = sum;
        end
    endfunction

endpackage

// File: rtl/fp_acc_seq_chk.sv
// Protocol checker for the adder side of fp_acc_seq: operand stability and start/ready exclusion.
module fp_acc_seq_chk (
    input logic        clk,
    input logic        rst,
    input logic        in_ready,
    input logic        add_start,
    input logic        add_ready,
    input logic [31:0] add_opa,
    input logic [31:0] add_opb
);

    logic        pending_r;
    logic [31:0] opa_q_r;
    logic [31:0] opb_q_r;

    // Track an outstanding add; it ends on completion or once the sequencer is accepting input again.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_r <= 1'b0;
            opa_q_r   <= 32'h00000000;
            opb_q_r   <= 32'h00000000;
        end else if (add_start) begin
            pending_r <= 1'b1;
            opa_q_r   <= add_opa;
            opb_q_r   <= add_opb;
        end else if (add_ready || in_ready) begin
            pending_r <= 1'b0;
        end else begin
            pending_r <= pending_r;
        end
    end

    a_ops_stable: assert property (@(posedge clk) disable iff (!rst)
        pending_r |-> ((add_opa == opa_q_r) && (add_opb == opb_q_r)));

    a_start_not_ready: assert property (@(posedge clk) disable iff (!rst)
        !(add_start && add_ready));

endmodule

// File: rtl/fp_acc_seq.sv
// Sequences an external FP adder to sum a stream of IEEE-754 singles into one result per vector.
module fp_acc_seq
    import fp_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int TMO   = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [31:0]      add_opa,
    output logic [31:0]      add_opb,
    output logic             add_start,
    input  logic [31:0]      add_sum,
    input  logic             add_ready,
    output logic [31:0]      acc_out,
    output logic             acc_valid,
    output logic [CNT_W-1:0] acc_count,
    output logic             err_tmo
);

    localparam int TMO_W = $clog2(TMO + 1);

    state_t             state_r, state_s;
    logic [31:0]        sum_r, sum_s;
    logic [31:0]        opa_r, opa_s;
    logic [31:0]        opb_r, opb_s;
    logic               last_r, last_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic               err_r, err_s;
    logic [TMO_W-1:0]   tmo_r, tmo_s;
    logic               xfer_s;

    logic               in_ready_r;
    logic               add_start_r;
    logic               acc_valid_r;
    logic [31:0]        acc_out_r;
    logic [CNT_W-1:0]   acc_count_r;
    logic               err_tmo_r;

    // State register; reset abandons any vector in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= WAIT_IN;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and next-datapath decode; everything holds unless a state says otherwise.
    always_comb begin
        state_s = state_r;
        sum_s   = sum_r;
        opa_s   = opa_r;
        opb_s   = opb_r;
        last_s  = last_r;
        cnt_s   = cnt_r;
        err_s   = err_r;
        tmo_s   = tmo_r;
        xfer_s  = in_valid && in_ready_r;
        case (state_r)
            WAIT_IN: begin
                if (xfer_s) begin
                    opa_s   = sum_r;
                    opb_s   = in_data;
                    last_s  = in_last;
                    state_s = ISSUE;
                end else begin
                    state_s = WAIT_IN;
                end
            end
            ISSUE: begin
                tmo_s   = {TMO_W{1'b0}};
                state_s = WAIT_ADD;
            end
            WAIT_ADD: begin
                if (add_ready) begin
                    sum_s = add_sum;
                    if (cnt_r != {CNT_W{1'b1}}) begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end else begin
                        cnt_s = cnt_r;
                    end
                    state_s = last_r ? DONE : WAIT_IN;
                end else if (tmo_r == TMO_W'(TMO - 1)) begin
                    // Adder never answered: remaining elements of this vector are discarded.
                    err_s   = 1'b1;
                    state_s = last_r ? DONE : DRAIN;
                end else begin
                    tmo_s = tmo_r + TMO_W'(1);
                end
            end
            DRAIN: begin
                if (xfer_s && in_last) begin
                    state_s = DONE;
                end else begin
                    state_s = DRAIN;
                end
            end
            DONE: begin
                sum_s   = FP_POS_ZERO;
                cnt_s   = {CNT_W{1'b0}};
                err_s   = 1'b0;
                state_s = WAIT_IN;
            end
            default: begin
                sum_s   = FP_POS_ZERO;
                cnt_s   = {CNT_W{1'b0}};
                err_s   = 1'b0;
                state_s = WAIT_IN;
            end
        endcase
    end

    // Datapath and registered outputs, all derived from the decoded next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_r       <= FP_POS_ZERO;
            opa_r       <= FP_POS_ZERO;
            opb_r       <= FP_POS_ZERO;
            last_r      <= 1'b0;
            cnt_r       <= {CNT_W{1'b0}};
            err_r       <= 1'b0;
            tmo_r       <= {TMO_W{1'b0}};
            in_ready_r  <= 1'b0;
            add_start_r <= 1'b0;
            acc_valid_r <= 1'b0;
            acc_out_r   <= FP_POS_ZERO;
            acc_count_r <= {CNT_W{1'b0}};
            err_tmo_r   <= 1'b0;
        end else begin
            sum_r       <= sum_s;
            opa_r       <= opa_s;
            opb_r       <= opb_s;
            last_r      <= last_s;
            cnt_r       <= cnt_s;
            err_r       <= err_s;
            tmo_r       <= tmo_s;
            in_ready_r  <= (state_s == WAIT_IN) || (state_s == DRAIN);
            add_start_r <= (state_s == ISSUE);
            acc_valid_r <= (state_s == DONE);
            if (state_s == DONE) begin
                acc_out_r   <= sel_result(err_s, sum_s);
                acc_count_r <= cnt_s;
                err_tmo_r   <= err_s;
            end else begin
                acc_out_r   <= acc_out_r;
                acc_count_r <= acc_count_r;
                err_tmo_r   <= 1'b0;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign add_opa   = opa_r;
    assign add_opb   = opb_r;
    assign add_start = add_start_r;
    assign acc_out   = acc_out_r;
    assign acc_valid = acc_valid_r;
    assign acc_count = acc_count_r;
    assign err_tmo   = err_tmo_r;

endmodule

// File: tb/tb_fp_acc_seq.sv
// Directed bench for fp_acc_seq with a table-driven adder model.
module tb_fp_acc_seq;
    import fp_pkg::*;

    localparam int LAT = 10;

    logic        clk;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [31:0] add_opa;
    logic [31:0] add_opb;
    logic        add_start;
    logic [31:0] add_sum;
    logic        add_ready;
    logic [31:0] acc_out;
    logic        acc_valid;
    logic [7:0]  acc_count;
    logic        err_tmo;

    int checks   = 0;
    int failures = 0;

    // adder model control and bookkeeping
    int          starts      = 0;
    int          drop_idx    = 0;
    bit          model_en    = 1'b1;
    int          inject_req  = 0;
    int          inject_done = 0;
    logic [31:0] inject_val  = 32'h00000000;
    bit          busy        = 1'b0;
    int          cd          = 0;
    logic [31:0] result      = 32'h00000000;

    fp_acc_seq #(.CNT_W(8), .TMO(64)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .add_opa(add_opa), .add_opb(add_opb), .add_start(add_start),
        .add_sum(add_sum), .add_ready(add_ready),
        .acc_out(acc_out), .acc_valid(acc_valid), .acc_count(acc_count), .err_tmo(err_tmo)
    );

    fp_acc_seq_chk chk_i (
        .clk(clk), .rst(rst), .in_ready(in_ready),
        .add_start(add_start), .add_ready(add_ready),
        .add_opa(add_opa), .add_opb(add_opb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hand-computed single-precision sums for the operand pairs this bench produces.
    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            64'h00000000_3F800000: fadd = 32'h3F800000;
            64'h3F800000_40000000: fadd = 32'h40400000;
            64'h40400000_40400000: fadd = 32'h40C00000;
            64'h00000000_7F800000: fadd = 32'h7F800000;
            64'h7F800000_3F800000: fadd = 32'h7F800000;
            64'h00000000_40000000: fadd = 32'h40000000;
            default:               fadd = 32'h7FC00001;
        endcase
    endfunction

    // Adder model: answers each add_start after LAT cycles, unless dropped or disabled.
    initial begin
        add_ready = 1'b0;
        add_sum   = 32'h00000000;
        forever begin
            @(negedge clk);
            if (add_ready) add_ready = 1'b0;
            if (inject_req != inject_done) begin
                add_sum     = inject_val;
                add_ready   = 1'b1;
                inject_done = inject_done + 1;
            end else if (busy) begin
                if (cd == 0) begin
                    add_sum   = result;
                    add_ready = 1'b1;
                    busy      = 1'b0;
                end else begin
                    cd = cd - 1;
                end
            end
            if (add_start) begin
                starts = starts + 1;
                if (model_en && (starts != drop_idx)) begin
                    busy   = 1'b1;
                    cd     = LAT - 1;
                    result = fadd(add_opa, add_opb);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        for (int i = 0; i < 300; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("send_accept", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_result(input string tag, input logic [31:0] exp_out,
                               input logic [7:0] exp_cnt, input logic exp_err);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (acc_valid) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_valid"}, {31'd0, got}, 32'd1);
        chk({tag, "_out"}, acc_out, exp_out);
        chk({tag, "_count"}, {24'd0, acc_count}, {24'd0, exp_cnt});
        chk({tag, "_err"}, {31'd0, err_tmo}, {31'd0, exp_err});
        @(negedge clk);
        chk({tag, "_pulse"}, {31'd0, acc_valid}, 32'd0);
    endtask

    initial begin
        int s0;
        int gap;
        bit seen;
        rst      = 1'b0;
        in_data  = 32'h00000000;
        in_valid = 1'b0;
        in_last  = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_add_start", {31'd0, add_start}, 32'd0);
        chk("rst_acc_valid", {31'd0, acc_valid}, 32'd0);
        chk("rst_acc_out", acc_out, 32'h00000000);
        chk("rst_acc_count", {24'd0, acc_count}, 32'd0);
        chk("rst_opa", add_opa, 32'h00000000);
        chk("rst_opb", add_opb, 32'h00000000);
        chk("rst_err", {31'd0, err_tmo}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // single element 1.0
        s0 = starts;
        send(32'h3F800000, 1'b1);
        wait_result("single", 32'h3F800000, 8'd1, 1'b0);
        chk("single_starts", starts - s0, 32'd1);
        repeat (5) @(negedge clk);
        chk("hold_out", acc_out, 32'h3F800000);
        chk("hold_count", {24'd0, acc_count}, 32'd1);

        // 1.0 + 2.0 + 3.0 with random gaps
        s0 = starts;
        gap = $urandom_range(0, 3);
        repeat (gap) @(negedge clk);
        send(32'h3F800000, 1'b0);
        gap = $urandom_range(0, 3);
        repeat (gap) @(negedge clk);
        send(32'h40000000, 1'b0);
        gap = $urandom_range(0, 3);
        repeat (gap) @(negedge clk);
        send(32'h40400000, 1'b1);
        wait_result("three", 32'h40C00000, 8'd3, 1'b0);
        chk("three_starts", starts - s0, 32'd3);

        // element 2 of 4 never answered -> timeout, drain, NaN result
        s0 = starts;
        drop_idx = starts + 2;
        send(32'h3F800000, 1'b0);
        send(32'h40000000, 1'b0);
        send(32'h40400000, 1'b0);
        send(32'h40800000, 1'b1);
        wait_result("tmo", 32'hFFC00000, 8'd1, 1'b1);
        chk("tmo_starts", starts - s0, 32'd2);
        send(32'h3F800000, 1'b1);
        wait_result("after_tmo", 32'h3F800000, 8'd1, 1'b0);

        // +inf + 1.0
        send(32'h7F800000, 1'b0);
        send(32'h3F800000, 1'b1);
        wait_result("inf", 32'h7F800000, 8'd2, 1'b0);

        // reset while waiting on the adder, then a stray add_ready
        model_en = 1'b0;
        send(32'h3F800000, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        inject_val = 32'h3F800000;
        inject_req = inject_req + 1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (acc_valid) seen = 1'b1;
        end
        chk("rst_mid_no_valid", {31'd0, seen}, 32'd0);
        chk("rst_mid_out", acc_out, 32'h00000000);
        chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
        model_en = 1'b1;
        send(32'h40000000, 1'b1);
        wait_result("after_rst", 32'h40000000, 8'd1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_acc_seq.md
FP_ACC_SEQ -- requirements
Module: fp_acc_seq

Interface
REQ-001 Parameter CNT_W, default 8: width of element counter acc_count.
REQ-002 Parameter TMO, default 64: max cycles waiting for add_ready per issued add.
REQ-003 clk  in  1  clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 in_data  in  32  IEEE-754 single element.
REQ-006 in_valid  in  1  element present.
REQ-007 in_last  in  1  element is last of vector; qualified by in_valid.
REQ-008 in_ready  out  1  block accepts element this cycle.
REQ-009 add_opa / add_opb  out  32  adder operands (running sum / element).
REQ-010 add_start  out  1  one-cycle adder request.
REQ-011 add_sum  in  32  adder result, valid when add_ready=1.
REQ-012 add_ready  in  1  one-cycle adder completion pulse.
REQ-013 acc_out  out  32  final vector sum; acc_valid  out  1  one-cycle result pulse.
REQ-014 acc_count  out  CNT_W  elements accumulated in last vector; err_tmo  out  1  adder timeout, valid with acc_valid.

Function
REQ-015 States: WAIT_IN, ISSUE, WAIT_ADD, DRAIN, DONE; reset state WAIT_IN.
REQ-016 Handshake: transfer when in_valid && in_ready; in_ready=1 only in WAIT_IN and DRAIN.
REQ-017 Running sum seeded 32'h00000000 at vector start (reset, and on leaving DONE); count cleared likewise.
REQ-018 WAIT_IN transfer: latch add_opa=running sum, add_opb=in_data, latch in_last; -> ISSUE.
REQ-019 ISSUE: add_start=1 for exactly one cycle; -> WAIT_ADD; add_opa/add_opb held stable from ISSUE until add_ready or timeout.
REQ-020 add_start never asserted in a cycle where add_ready=1; minimum one cycle between add_ready and next add_start.
REQ-021 WAIT_ADD on add_ready: running sum<=add_sum, count+1 (saturating at all-ones); latched last -> DONE, else -> WAIT_IN.
REQ-022 WAIT_ADD timeout: TMO cycles counted from ISSUE exit without add_ready -> set error flag; latched last -> DONE, else -> DRAIN.
REQ-023 DRAIN: accept and discard elements; transfer with in_last=1 -> DONE.
REQ-024 add_ready outside WAIT_ADD ignored (no state or sum change).
REQ-025 DONE: acc_valid=1 one cycle, acc_out=running sum (32'hFFC00000 if error), err_tmo=error flag; -> WAIT_IN, error flag cleared.
REQ-026 acc_out, acc_count hold value until next DONE.
REQ-027 No arithmetic in block; NaN/inf/zero handling delegated to adder; -0 single element yields adder's +0+(-0) result.
REQ-028 Latency per element: transfer -> ISSUE 1 cycle -> adder latency -> WAIT_IN/DONE 1 cycle.

Reset
REQ-029 rst low: state WAIT_IN, in_ready=0 during reset then 1, add_start=0, acc_valid=0, err_tmo=0, acc_out=0, acc_count=0, add_opa=add_opb=0, running sum 0, timeout counter 0.
REQ-030 Reset mid-operation (any state) abandons vector; no acc_valid emitted; late add_ready after reset ignored.

Structure
REQ-031 Shared package fp_pkg: FP_POS_ZERO=32'h00000000, FP_QNAN=32'hFFC00000, state enumeration.
REQ-032 Single flat module; adder instantiated beside it at top level, not inside; no sub-module.

Verification
REQ-033 Single element 3F800000 (1.0) with last, adder model 10-cycle latency -> acc_out=3F800000, acc_count=1, err_tmo=0.
REQ-034 Elements 3F800000, 40000000, 40400000 (last) with random in_valid gaps -> acc_out=40C00000, acc_count=3, one add_start per element.
REQ-035 Adder model never responds on element 2 of 4 -> after 64 cycles DRAIN accepts elements 3,4; acc_valid with acc_out=FFC00000, err_tmo=1; next vector {1.0 last} -> 3F800000, err_tmo=0.
REQ-036 Elements 7F800000 (+inf), 3F800000 (last) -> acc_out=7F800000.
REQ-037 rst asserted in WAIT_ADD, add_ready pulsed 2 cycles after release -> no acc_valid, no sum change; next vector {40000000 last} -> 40000000.
REQ-038 Checker: add_opa/add_opb stable between add_start and add_ready; add_start never coincident with add_ready.
